// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the sync-read program ROM and buffers the
// returned bytes with their fetch addresses in a show-ahead prefetch FIFO for the decoder.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  halt,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0]         PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    entry_t                mem_q [FIFO_DEPTH];
    entry_t                mem_d [FIFO_DEPTH];
    entry_t                hold_q, hold_d;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         occupancy;
    entry_t                head;

    // Decoder handshake: a byte transfers on any cycle with instr_valid & instr_ready;
    // instr_valid never depends on instr_ready, and the head stays stable until popped or flushed.
    always_comb begin
        rom_address     = redirect_valid ? redirect_addr : pc_q;
        occupancy       = count_q + {{(CW-1){1'b0}}, inflight_q};
        issue           = redirect_valid | (~halt & (occupancy < FULL_CNT));
        head            = mem_q[rd_ptr_q];
        instr_valid     = (count_q != '0);
        instr_data      = instr_valid ? head.data : hold_q.data;
        instr_addr      = instr_valid ? head.addr : hold_q.addr;
        pop             = instr_valid & instr_ready;
        // A redirect discards whatever lands this cycle along with the buffered bytes.
        push            = inflight_q & ~redirect_valid;

        pc_d            = issue ? (rom_address + ADDR_ONE) : pc_q;
        inflight_d      = issue;
        inflight_addr_d = issue ? rom_address : inflight_addr_q;
        hold_d          = instr_valid ? head : hold_q;

        mem_d    = mem_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{addr: inflight_addr_q, data: rom_data};
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q            <= RESET_VECTOR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            hold_q          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            hold_q          <= hold_d;
            mem_q           <= mem_d;
        end
    end

    // The issue gate reserves a slot for every read in flight, so a full FIFO never sees a push.
    push_while_full_a : assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (count_q == FULL_CNT)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based transaction model of the fetch stage and a behavioural ROM.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [11:0] rom_address;
    logic [7:0]  rom_data;
    logic        redirect_valid;
    logic [11:0] redirect_addr;
    logic        halt;
    logic        instr_valid;
    logic [7:0]  instr_data;
    logic [11:0] instr_addr;
    logic        instr_ready;

    instr_fetch_unit #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (4),
        .RESET_VECTOR(12'h000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rom_address   (rom_address),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_addr    (instr_addr),
        .instr_ready   (instr_ready)
    );

    // ---------------- clock / ROM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [4096];
    always @(posedge clk) rom_data <= rom[rom_address];

    // ---------------- model / scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [19:0] exp_q[$];     // {addr, data} the decoder should see, head first
    logic [19:0] popped_q[$];  // {addr, data} actually accepted from the DUT
    logic [11:0] m_pc;
    bit          m_inf;
    logic [11:0] m_ia;
    logic [19:0] m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc   = 12'h000;
        m_inf  = 0;
        m_ia   = 12'h000;
        m_last = 20'h0;
        exp_q.delete();
    endtask

    // Fetch rules applied at a clock edge, using the inputs held across that edge.
    task automatic model_edge();
        logic [11:0] a;
        bit          iss;
        a   = redirect_valid ? redirect_addr : m_pc;
        iss = redirect_valid || (!halt && (exp_q.size() + int'(m_inf)) < 4);
        if (exp_q.size() != 0) begin
            m_last = exp_q[0];
            if (instr_ready) void'(exp_q.pop_front());
        end
        if (redirect_valid) exp_q.delete();
        else if (m_inf) exp_q.push_back({m_ia, rom[m_ia]});
        if (iss) begin
            m_pc  = a + 12'd1;
            m_inf = 1;
            m_ia  = a;
        end else begin
            m_inf = 0;
        end
    endtask

    // Called at a negedge with inputs already driven: check, cross the edge, return at next negedge.
    task automatic cyc();
        logic [19:0] head;
        logic [11:0] exp_addr;
        #1;
        exp_addr = redirect_valid ? redirect_addr : m_pc;
        head     = (exp_q.size() != 0) ? exp_q[0] : m_last;
        chk("rom_address", 32'(rom_address), 32'(exp_addr));
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        chk("instr_addr", 32'(instr_addr), 32'(head[19:8]));
        chk("instr_data", 32'(instr_data), 32'(head[7:0]));
        if (instr_valid === 1'b1 && instr_ready) popped_q.push_back({instr_addr, instr_data});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        #1;
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_data"}, 32'(instr_data), 32'h0);
        chk({tag, "_addr"}, 32'(instr_addr), 32'h0);
        chk({tag, "_rom_address"}, 32'(rom_address), 32'h000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        redirect_valid = 0;
        redirect_addr  = 12'h000;
        halt           = 0;
        reset_n        = 0;
        check_reset_outputs("reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic chk_pop(input string tag, input int idx, input logic [11:0] a, input logic [7:0] d);
        logic [19:0] e;
        e = (idx < popped_q.size()) ? popped_q[idx] : 20'hxxxxx;
        chk({tag, "_addr"}, 32'(e[19:8]), 32'(a));
        chk({tag, "_data"}, 32'(e[7:0]), 32'(d));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n        = 0;
        redirect_valid = 0;
        redirect_addr  = 12'h000;
        halt           = 0;
        instr_ready    = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) rom[i] = 8'hA0 + 8'(i);
        rom[12'h123] = 8'h5C;

        // 1: streaming from reset, first byte two cycles after release
        instr_ready = 1;
        do_reset();
        popped_q.delete();
        cyc();
        cyc();
        #1;
        chk("t1_valid_c2", 32'(instr_valid), 32'h1);
        chk("t1_data_c2", 32'(instr_data), 32'hA0);
        chk("t1_addr_c2", 32'(instr_addr), 32'h000);
        run(10);
        chk("t1_count", 32'(popped_q.size()), 32'd10);
        for (int i = 0; i < 8; i++) chk_pop("t1_seq", i, 12'(i), 8'hA0 + 8'(i));

        // 2: decoder stalled fills exactly four entries, PC parks at 004
        instr_ready = 0;
        do_reset();
        run(10);
        #1;
        chk("t2_pc_hold", 32'(rom_address), 32'h004);
        chk("t2_head", 32'(instr_data), 32'hA0);
        instr_ready = 1;
        popped_q.delete();
        run(12);
        chk("t2_enough", 32'(popped_q.size() >= 8), 32'h1);
        for (int i = 0; i < 8; i++) chk_pop("t2_seq", i, 12'(i), 8'hA0 + 8'(i));

        // 3: redirect with three buffered entries and one read in flight
        instr_ready = 0;
        do_reset();
        run(4);
        redirect_valid = 1;
        redirect_addr  = 12'h123;
        cyc();
        redirect_valid = 0;
        instr_ready    = 1;
        popped_q.delete();
        cyc();
        #1;
        chk("t3_valid_r2", 32'(instr_valid), 32'h1);
        chk("t3_data_r2", 32'(instr_data), 32'h5C);
        chk("t3_addr_r2", 32'(instr_addr), 32'h123);
        run(3);
        chk_pop("t3_first", 0, 12'h123, 8'h5C);

        // 4: PC wrap past the top of the ROM
        redirect_valid = 1;
        redirect_addr  = 12'hFFE;
        cyc();
        redirect_valid = 0;
        popped_q.delete();
        run(5);
        chk("t4_count", 32'(popped_q.size()), 32'd4);
        chk_pop("t4_a", 0, 12'hFFE, rom[12'hFFE]);
        chk_pop("t4_b", 1, 12'hFFF, rom[12'hFFF]);
        chk_pop("t4_c", 2, 12'h000, 8'hA0);
        chk_pop("t4_d", 3, 12'h001, 8'hA1);

        // 5: halt drains, a redirect during halt fetches one byte, release resumes after it
        run(3);
        halt = 1;
        popped_q.delete();
        run(6);
        chk("t5_halt_drained", 32'(popped_q.size()), 32'd2);
        #1;
        chk("t5_halt_idle", 32'(instr_valid), 32'h0);
        redirect_valid = 1;
        redirect_addr  = 12'h345;
        popped_q.delete();
        cyc();
        redirect_valid = 0;
        run(5);
        chk("t5_one_byte", 32'(popped_q.size()), 32'd1);
        chk_pop("t5_target", 0, 12'h345, rom[12'h345]);
        halt = 0;
        popped_q.delete();
        run(4);
        chk("t5_resume_count", 32'(popped_q.size()), 32'd2);
        chk_pop("t5_resume", 0, 12'h346, rom[12'h346]);

        // 6: asynchronous reset in mid-stream
        run(3);
        #2;
        reset_n = 0;
        check_reset_outputs("t6_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        popped_q.delete();
        run(4);
        chk("t6_restart_count", 32'(popped_q.size()), 32'd2);
        chk_pop("t6_restart", 0, 12'h000, 8'hA0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 7) == 0) ? ~halt : halt;
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_addr  = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3))
                                                         : 12'($urandom);
            cyc();
        end
        redirect_valid = 0;
        halt           = 0;
        run(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
